// File: rtl/regfile_scoreboard.sv
// Multi-port register file with write-through bypass and a per-register
// pending-write scoreboard so hazard logic can see in-flight producers.

module regfile_rd_port #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int CNT_W    = 2,
    parameter int ZERO_REG = 1,
    parameter int DEPTH    = 1 << ADDR_W
) (
    input  logic [ADDR_W-1:0]                  i_addr,
    input  logic [DEPTH-1:0][DATA_W-1:0]       i_mem,
    input  logic [DEPTH-1:0][CNT_W-1:0]        i_cnt,
    input  logic                               i_wr_en,
    input  logic [ADDR_W-1:0]                  i_wr_addr,
    input  logic [DATA_W-1:0]                  i_wr_data,
    output logic [DATA_W-1:0]                  o_data,
    output logic                               o_busy
);
    logic              w_zero;
    logic              w_bypass;
    logic [CNT_W-1:0]  w_cnt;

    assign w_zero   = (ZERO_REG != 0) && (i_addr == '0);
    assign w_bypass = i_wr_en && (i_wr_addr == i_addr);
    assign w_cnt    = i_cnt[i_addr];

    always_comb begin
        o_data = i_mem[i_addr];
        if (w_bypass)
            o_data = i_wr_data;
        if (w_zero)
            o_data = '0;
    end

    // A same-cycle retire counts as already delivered since its data is bypassed.
    always_comb begin
        o_busy = 1'b0;
        if (!w_zero)
            o_busy = w_bypass ? (w_cnt > CNT_W'(1)) : (w_cnt != '0);
    end
endmodule

module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int CNT_W    = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       iss_en,
    input  logic [ADDR_W-1:0]          iss_addr,
    input  logic                       flush,
    output logic                       sb_ovf
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DEPTH-1:0][DATA_W-1:0] r_mem;
    logic [DEPTH-1:0][CNT_W-1:0]  w_cnt;
    logic [DEPTH-1:0]             w_ovf_hit;
    logic                         r_sb_ovf;
    logic                         w_wr_store;

    assign w_wr_store = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

    always_ff @(posedge clk) begin
        if (rst)
            r_mem <= '0;
        else if (w_wr_store)
            r_mem[wr_addr] <= wr_data;
    end

    for (genvar r = 0; r < DEPTH; r++) begin : g_cnt
        localparam bit TRACK = !((ZERO_REG != 0) && (r == 0));
        logic [CNT_W-1:0] r_cnt;
        logic             w_iss;
        logic             w_ret;
        logic             w_sat;

        assign w_iss        = iss_en && (iss_addr == ADDR_W'(r)) && TRACK;
        assign w_ret        = wr_en && (wr_addr == ADDR_W'(r));
        assign w_sat        = (r_cnt == CNT_MAX);
        // Issue+retire on the same register nets to zero, so it never overflows.
        assign w_ovf_hit[r] = w_iss && !w_ret && w_sat && !flush;
        assign w_cnt[r]     = r_cnt;

        always_ff @(posedge clk) begin
            if (rst || flush)
                r_cnt <= '0;
            else if (w_iss && !w_ret) begin
                if (!w_sat)
                    r_cnt <= r_cnt + 1'b1;
            end else if (w_ret && !w_iss && (r_cnt != '0))
                r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_sb_ovf <= 1'b0;
        else if (|w_ovf_hit)
            r_sb_ovf <= 1'b1;
    end

    assign sb_ovf = r_sb_ovf;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        regfile_rd_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .CNT_W    (CNT_W),
            .ZERO_REG (ZERO_REG),
            .DEPTH    (DEPTH)
        ) u_rd (
            .i_addr    (rd_addr[i*ADDR_W +: ADDR_W]),
            .i_mem     (r_mem),
            .i_cnt     (w_cnt),
            .i_wr_en   (wr_en),
            .i_wr_addr (wr_addr),
            .i_wr_data (wr_data),
            .o_data    (rd_data[i*DATA_W +: DATA_W]),
            .o_busy    (rd_busy[i])
        );
    end
endmodule
